// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use stalls, multi-cycle
// multiply occupancy of EX, taken-branch flushes, plus saturating event counters.
module hazard_control_unit #(
  parameter int MULT_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IDEXMemRead,
  input  logic [4:0]  IDEXRegRd,
  input  logic [4:0]  IFIDR1,
  input  logic [4:0]  IFIDR2,
  input  logic        IFIDUsesR2,
  input  logic        MultStart,
  input  logic        BranchTaken,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXWrite,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        EXMEMFlush,
  output logic        MultBusy,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  typedef enum logic [0:0] {RUN = 1'b0, MULT_BUSY = 1'b1} state_t;

  // The MultStart cycle is itself the first EX cycle, so the busy phase is one shorter.
  localparam logic [3:0] MCNT_LOAD = 4'(MULT_LATENCY - 2);

  state_t     state;
  logic [3:0] mcnt;
  logic       loadUse;

  // Load-use detection: a load's destination is read by the instruction right behind it
  always_comb begin
    loadUse = 1'b0;
    if (IDEXMemRead && (IDEXRegRd != 5'd0) &&
        ((IDEXRegRd == IFIDR1) || (IFIDUsesR2 && (IDEXRegRd == IFIDR2)))) begin
      loadUse = 1'b1;
    end else begin
      loadUse = 1'b0;
    end
  end

  // Pipeline enables and flushes, decoded from current state and this cycle's inputs
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    EXMEMFlush = 1'b0;
    MultBusy   = 1'b0;
    if (reset) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXFlush  = 1'b1;
      EXMEMFlush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (BranchTaken) begin
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
          end else if (MultStart) begin
            PCWrite = 1'b1;
          end else if (loadUse) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
          end else begin
            PCWrite = 1'b1;
          end
        end
        MULT_BUSY: begin
          // A taken branch means the multiply was wrong-path: abort it and redirect.
          if (BranchTaken) begin
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
          end else begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMFlush = 1'b1;
            MultBusy   = 1'b1;
          end
        end
        default: begin
          PCWrite = 1'b1;
        end
      endcase
    end
  end

  // FSM state, multiply down-counter and saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      mcnt       <= 4'd0;
      StallCount <= 16'd0;
      FlushCount <= 16'd0;
    end else begin
      if (!PCWrite && (StallCount != 16'hFFFF)) begin
        StallCount <= StallCount + 16'd1;
      end
      if (BranchTaken && (FlushCount != 16'hFFFF)) begin
        FlushCount <= FlushCount + 16'd1;
      end
      case (state)
        RUN: begin
          if (!BranchTaken && MultStart) begin
            state <= MULT_BUSY;
            mcnt  <= MCNT_LOAD;
          end else begin
            state <= RUN;
          end
        end
        MULT_BUSY: begin
          if (BranchTaken || (mcnt == 4'd0)) begin
            state <= RUN;
            mcnt  <= 4'd0;
          end else begin
            mcnt <= mcnt - 4'd1;
          end
        end
        default: begin
          state <= RUN;
          mcnt  <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model.
module tb_hazard_control_unit;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        IDEXMemRead;
  logic [4:0]  IDEXRegRd;
  logic [4:0]  IFIDR1;
  logic [4:0]  IFIDR2;
  logic        IFIDUsesR2;
  logic        MultStart;
  logic        BranchTaken;
  logic        PCWrite, IFIDWrite, IDEXWrite;
  logic        IFIDFlush, IDEXFlush, EXMEMFlush, MultBusy;
  logic [15:0] StallCount, FlushCount;

  int testsRun = 0;
  int testsFailed = 0;

  // Model state: remaining busy cycles of the multiply and the event tallies.
  int busyLeft = 0;
  int stallM = 0;
  int flushM = 0;

  logic [6:0] outVec;
  assign outVec = {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, MultBusy};

  hazard_control_unit #(.MULT_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .IDEXMemRead(IDEXMemRead), .IDEXRegRd(IDEXRegRd),
    .IFIDR1(IFIDR1), .IFIDR2(IFIDR2), .IFIDUsesR2(IFIDUsesR2), .MultStart(MultStart),
    .BranchTaken(BranchTaken), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .IDEXWrite(IDEXWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
    .EXMEMFlush(EXMEMFlush), .MultBusy(MultBusy), .StallCount(StallCount),
    .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  function automatic logic luNow();
    return IDEXMemRead && (IDEXRegRd != 5'd0) &&
           ((IDEXRegRd == IFIDR1) || (IFIDUsesR2 && (IDEXRegRd == IFIDR2)));
  endfunction

  // Expected {PCWrite,IFIDWrite,IDEXWrite,IFIDFlush,IDEXFlush,EXMEMFlush,MultBusy}
  function automatic logic [6:0] expOut();
    if (reset)            return 7'b000_111_0;
    if (busyLeft > 0)     return BranchTaken ? 7'b111_111_0 : 7'b000_001_1;
    if (BranchTaken)      return 7'b111_111_0;
    if (MultStart)        return 7'b111_000_0;
    if (luNow())          return 7'b001_010_0;
    return 7'b111_000_0;
  endfunction

  task automatic setIn(input logic r, input logic mr, input int rd, input int r1,
                       input int r2, input logic u2, input logic ms, input logic bt);
    reset = r; IDEXMemRead = mr; IDEXRegRd = 5'(rd); IFIDR1 = 5'(r1);
    IFIDR2 = 5'(r2); IFIDUsesR2 = u2; MultStart = ms; BranchTaken = bt;
    #2;
  endtask

  task automatic idle();
    setIn(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock, updating the model with the inputs that were applied.
  task automatic step();
    logic [6:0] e;
    e = expOut();
    @(posedge clk);
    if (reset) begin
      busyLeft = 0; stallM = 0; flushM = 0;
    end else begin
      if (!e[6] && stallM < 65535) stallM++;
      if (BranchTaken && flushM < 65535) flushM++;
      if (busyLeft > 0) busyLeft = BranchTaken ? 0 : busyLeft - 1;
      else if (!BranchTaken && MultStart) busyLeft = LAT - 1;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      setIn(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      testsRun++;
      if (outVec !== 7'b000_111_0) begin
        testsFailed++; $display("FAIL reset_outputs: got %b expected %b", outVec, 7'b000_111_0);
      end
      step();
    end
    idle();
    testsRun++;
    if (outVec !== 7'b111_000_0 || StallCount !== 16'd0 || FlushCount !== 16'd0) begin
      testsFailed++;
      $display("FAIL after_reset: got %b/%0d/%0d expected 1110000/0/0", outVec, StallCount, FlushCount);
    end
  endtask

  task automatic test_load_use();
    setIn(1'b0, 1'b1, 8, 8, 3, 1'b1, 1'b0, 1'b0);
    testsRun++;
    if (outVec !== 7'b001_010_0) begin
      testsFailed++; $display("FAIL lu_stall: got %b expected %b", outVec, 7'b001_010_0);
    end
    step(); idle();
    testsRun++;
    if (StallCount !== 16'd1) begin
      testsFailed++; $display("FAIL lu_count: got %0d expected 1", StallCount);
    end
    setIn(1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    testsRun++;
    if (PCWrite !== 1'b1 || IDEXFlush !== 1'b0) begin
      testsFailed++; $display("FAIL lu_r0: got PCWrite=%b IDEXFlush=%b expected 1 0", PCWrite, IDEXFlush);
    end
    step();
    setIn(1'b0, 1'b1, 8, 5, 8, 1'b0, 1'b0, 1'b0);
    testsRun++;
    if (PCWrite !== 1'b1 || IDEXFlush !== 1'b0) begin
      testsFailed++; $display("FAIL lu_nouse_r2: got PCWrite=%b IDEXFlush=%b expected 1 0", PCWrite, IDEXFlush);
    end
    step();
    setIn(1'b0, 1'b1, 8, 5, 8, 1'b1, 1'b0, 1'b0);
    testsRun++;
    if (PCWrite !== 1'b0) begin
      testsFailed++; $display("FAIL lu_use_r2: got PCWrite=%b expected 0", PCWrite);
    end
    step(); idle();
  endtask

  task automatic test_mult();
    int s0;
    s0 = stallM;
    setIn(1'b0, 1'b1, 8, 8, 0, 1'b0, 1'b1, 1'b0);
    testsRun++;
    if (outVec !== 7'b111_000_0) begin
      testsFailed++; $display("FAIL mult_start: got %b expected %b", outVec, 7'b111_000_0);
    end
    step(); idle();
    for (int i = 0; i < LAT - 1; i++) begin
      testsRun++;
      if (MultBusy !== 1'b1 || PCWrite !== 1'b0 || EXMEMFlush !== 1'b1) begin
        testsFailed++;
        $display("FAIL mult_busy_%0d: got MultBusy=%b PCWrite=%b EXMEMFlush=%b expected 1 0 1", i, MultBusy, PCWrite, EXMEMFlush);
      end
      step();
    end
    testsRun++;
    if (MultBusy !== 1'b0 || PCWrite !== 1'b1 || StallCount !== 16'(s0 + 3)) begin
      testsFailed++;
      $display("FAIL mult_end: got MultBusy=%b PCWrite=%b StallCount=%0d expected 0 1 %0d", MultBusy, PCWrite, StallCount, s0 + 3);
    end
  endtask

  task automatic test_branch();
    int s0, f0;
    s0 = stallM; f0 = flushM;
    setIn(1'b0, 1'b1, 8, 8, 0, 1'b0, 1'b1, 1'b1);
    testsRun++;
    if (outVec !== 7'b111_111_0) begin
      testsFailed++; $display("FAIL branch_flush: got %b expected %b", outVec, 7'b111_111_0);
    end
    step(); idle();
    testsRun++;
    if (FlushCount !== 16'(f0 + 1) || StallCount !== 16'(s0) || MultBusy !== 1'b0) begin
      testsFailed++;
      $display("FAIL branch_count: got flush=%0d stall=%0d busy=%b expected %0d %0d 0", FlushCount, StallCount, MultBusy, f0 + 1, s0);
    end
  endtask

  task automatic test_branch_mult();
    setIn(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    step(); idle(); step();
    setIn(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    testsRun++;
    if (PCWrite !== 1'b1 || IFIDFlush !== 1'b1 || IDEXFlush !== 1'b1 || EXMEMFlush !== 1'b1) begin
      testsFailed++; $display("FAIL branch_in_mult: got %b expected 111111x", outVec);
    end
    step(); idle();
    testsRun++;
    if (MultBusy !== 1'b0 || PCWrite !== 1'b1) begin
      testsFailed++; $display("FAIL mult_aborted: got MultBusy=%b PCWrite=%b expected 0 1", MultBusy, PCWrite);
    end
  endtask

  task automatic test_random();
    logic [6:0] e;
    for (int i = 0; i < 400; i++) begin
      setIn($urandom_range(0, 49) == 0, 1'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      e = expOut();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++; $display("FAIL rand_out_%0d: got %b expected %b", i, outVec, e);
      end
      step();
      testsRun++;
      if (StallCount !== 16'(stallM) || FlushCount !== 16'(flushM)) begin
        testsFailed++;
        $display("FAIL rand_cnt_%0d: got %0d/%0d expected %0d/%0d", i, StallCount, FlushCount, stallM, flushM);
      end
    end
    idle();
    while (busyLeft > 0) step();
  endtask

  task automatic test_saturation();
    setIn(1'b0, 1'b1, 7, 7, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) step();
    testsRun++;
    if (StallCount !== 16'hFFFF || stallM != 65535) begin
      testsFailed++; $display("FAIL stall_saturate: got %h expected ffff", StallCount);
    end
    idle();
    setIn(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    step(); idle(); step();
    setIn(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    testsRun++;
    if (outVec !== 7'b000_111_0) begin
      testsFailed++; $display("FAIL reset_in_mult: got %b expected %b", outVec, 7'b000_111_0);
    end
    step(); idle();
    testsRun++;
    if (outVec !== 7'b111_000_0 || StallCount !== 16'd0 || FlushCount !== 16'd0) begin
      testsFailed++;
      $display("FAIL after_mid_reset: got %b/%0d/%0d expected 1110000/0/0", outVec, StallCount, FlushCount);
    end
  endtask

  initial begin
    setIn(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_load_use();
    test_mult();
    test_branch();
    test_branch_mult();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
